// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the cosim deadlock-detection blocks.
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    BLOCKED = 2'd2
  } ch_state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  // Output channels stall on a full consumer, input channels on an empty producer.
  function automatic logic stall_of(input logic dir, input logic valid, input logic ready);
    return (dir == DIR_OUT) ? (valid & ~ready) : (ready & ~valid);
  endfunction

endpackage

// File: rtl/aesl_axis_stall_ch.sv
// One stream channel's stall FSM and saturating consecutive-stall counter.
module aesl_axis_stall_ch
  import aesl_deadlock_pkg::*;
#(
  parameter int unsigned STALL_THRESH = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clock_i,
  input  logic rst_n_i,
  input  logic enable_i,
  input  logic clear_i,
  input  logic valid_i,
  input  logic ready_i,
  input  logic dir_i,
  output logic blocked_o,
  output logic blocked_nxt_o,
  output logic enter_o
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             stall;

  assign stall   = stall_of(dir_i, valid_i, ready_i);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear_i || !enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stall) begin
            cnt_d = CNT_W'(1);
            if (STALL_THRESH == 1) state_d = BLOCKED;
            else                   state_d = STALL;
          end
        end
        STALL: begin
          if (!stall) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == THRESH_C) state_d = BLOCKED;
          end
        end
        BLOCKED: begin
          if (!stall) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign blocked_o     = (state_q == BLOCKED);
  assign blocked_nxt_o = (state_d == BLOCKED);
  assign enter_o       = blocked_nxt_o & ~blocked_o;

endmodule

// File: rtl/aesl_axis_block_detector.sv
// Per-channel AXI-stream stall detector with first-block latch for deadlock reports.
module aesl_axis_block_detector
  import aesl_deadlock_pkg::*;
#(
  parameter int unsigned NUM_CH       = 13,
  parameter int unsigned STALL_THRESH = 16,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_dir,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic              first_valid,
  output logic [IDX_W-1:0]  first_ch
);

  logic [NUM_CH-1:0] blocked_nxt;
  logic [NUM_CH-1:0] enter;
  logic [IDX_W-1:0]  enter_idx;
  logic              enter_found;
  logic              any_q;
  logic              first_valid_q;
  logic [IDX_W-1:0]  first_ch_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    aesl_axis_stall_ch #(
      .STALL_THRESH (STALL_THRESH),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clock_i       (clock),
      .rst_n_i       (reset_n),
      .enable_i      (enable),
      .clear_i       (clear),
      .valid_i       (ch_valid[g]),
      .ready_i       (ch_ready[g]),
      .dir_i         (ch_dir[g]),
      .blocked_o     (axis_block_sigs[g]),
      .blocked_nxt_o (blocked_nxt[g]),
      .enter_o       (enter[g])
    );
  end

  // Lowest index wins when several channels block on the same edge.
  always_comb begin
    enter_idx   = '0;
    enter_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (enter[i] && !enter_found) begin
        enter_idx   = IDX_W'(i);
        enter_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      any_q         <= 1'b0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
    end else begin
      any_q <= |blocked_nxt;
      if (clear) begin
        first_valid_q <= 1'b0;
        first_ch_q    <= '0;
      end else if (!first_valid_q && enter_found) begin
        first_valid_q <= 1'b1;
        first_ch_q    <= enter_idx;
      end
    end
  end

  assign any_block   = any_q;
  assign first_valid = first_valid_q;
  assign first_ch    = first_ch_q;

endmodule

// File: tb/tb_aesl_axis_block_detector.sv
// Bench for aesl_axis_block_detector: thresholds 16 and 1 checked against a run-length model.
module tb_aesl_axis_block_detector;

  localparam int N  = 13;
  localparam int IW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [N-1:0]  ch_valid = '0;
  logic [N-1:0]  ch_ready = '0;
  logic [N-1:0]  ch_dir = 13'h1FDF;

  logic [N-1:0]  d_sigs [2];
  logic          d_any  [2];
  logic          d_fv   [2];
  logic [IW-1:0] d_fc   [2];

  int            errors = 0;
  int            checks = 0;

  // Model state: consecutive stalled edges per channel since last reset/clear/disable.
  int            thr [2] = '{16, 1};
  int            run [2][N];
  logic [N-1:0]  m_sigs [2];
  logic          m_any  [2];
  logic          m_fv   [2];
  logic [IW-1:0] m_fc   [2];

  aesl_axis_block_detector #(.NUM_CH(13), .STALL_THRESH(16), .CNT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_dir(ch_dir),
    .axis_block_sigs(d_sigs[0]), .any_block(d_any[0]),
    .first_valid(d_fv[0]), .first_ch(d_fc[0])
  );

  aesl_axis_block_detector #(.NUM_CH(13), .STALL_THRESH(1), .CNT_W(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_dir(ch_dir),
    .axis_block_sigs(d_sigs[1]), .any_block(d_any[1]),
    .first_valid(d_fv[1]), .first_ch(d_fc[1])
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  // Behavioural model
  initial begin
    logic [N-1:0] nb;
    logic         st;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) run[k][i] = 0;
      m_sigs[k] = '0; m_any[k] = 1'b0; m_fv[k] = 1'b0; m_fc[k] = '0;
    end
    forever begin
      @(posedge clock or negedge reset_n);
      for (int k = 0; k < 2; k++) begin
        if (!reset_n) begin
          for (int i = 0; i < N; i++) run[k][i] = 0;
          m_sigs[k] = '0; m_any[k] = 1'b0; m_fv[k] = 1'b0; m_fc[k] = '0;
        end else begin
          nb = '0;
          for (int i = 0; i < N; i++) begin
            st = ch_dir[i] ? (ch_valid[i] && !ch_ready[i]) : (ch_ready[i] && !ch_valid[i]);
            if (clear || !enable) run[k][i] = 0;
            else if (st)          run[k][i] = (run[k][i] < 1000000) ? run[k][i] + 1 : run[k][i];
            else                  run[k][i] = 0;
            nb[i] = (run[k][i] >= thr[k]);
          end
          if (clear) begin
            m_fv[k] = 1'b0;
            m_fc[k] = '0;
          end else if (!m_fv[k] && ((nb & ~m_sigs[k]) != '0)) begin
            m_fv[k] = 1'b1;
            for (int i = N - 1; i >= 0; i--)
              if (nb[i] && !m_sigs[k][i]) m_fc[k] = IW'(i);
          end
          m_sigs[k] = nb;
          m_any[k]  = (nb != '0);
        end
      end
    end
  end

  // Compare process
  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("sigs[%0d]", k), 32'(d_sigs[k]), 32'(m_sigs[k]));
        chk($sformatf("any[%0d]", k),  32'(d_any[k]),  32'(m_any[k]));
        chk($sformatf("fv[%0d]", k),   32'(d_fv[k]),   32'(m_fv[k]));
        chk($sformatf("fc[%0d]", k),   32'(d_fc[k]),   32'(m_fc[k]));
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_sigs", 32'(d_sigs[0]), 32'h0);
    chk("rst_any",  32'(d_any[0]),  32'h0);
    chk("rst_fv",   32'(d_fv[0]),   32'h0);
    chk("rst_fc",   32'(d_fc[0]),   32'h0);
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(2);

    // ch3 output role stalled
    ch_valid[3] = 1'b1;
    tick(1);
    chk("t1_sigs", 32'(d_sigs[1]), 32'h0008);
    chk("t1_fc",   32'(d_fc[1]),   32'h3);
    tick(14);
    chk("ch3_pre", 32'(d_sigs[0]), 32'h0);
    tick(1);
    chk("ch3_sigs", 32'(d_sigs[0]), 32'h0008);
    chk("ch3_any",  32'(d_any[0]),  32'h1);
    chk("ch3_fv",   32'(d_fv[0]),   32'h1);
    chk("ch3_fc",   32'(d_fc[0]),   32'h3);
    ch_valid[3] = 1'b0;
    tick(1);
    chk("ch3_rel", 32'(d_sigs[0]), 32'h0);
    chk("ch3_hold", 32'(d_fc[0]), 32'h3);
    pulse_clear();
    chk("clr_fv", 32'(d_fv[0]), 32'h0);

    // ch5 input role, one transfer in the middle of the stall
    ch_ready[5] = 1'b1;
    tick(15);
    ch_valid[5] = 1'b1;
    tick(1);
    ch_valid[5] = 1'b0;
    tick(15);
    chk("ch5_none", 32'(d_sigs[0]), 32'h0);
    ch_ready[5] = 1'b0;
    tick(1);
    pulse_clear();

    // chs 2 and 9 simultaneously
    ch_valid[2] = 1'b1;
    ch_valid[9] = 1'b1;
    tick(15);
    chk("c29_pre", 32'(d_sigs[0]), 32'h0);
    tick(1);
    chk("c29_sigs", 32'(d_sigs[0]), 32'h0204);
    chk("c29_fc",   32'(d_fc[0]),   32'h2);
    ch_valid[2] = 1'b0;
    tick(1);
    chk("c29_rel", 32'(d_sigs[0]), 32'h0200);
    chk("c29_fc2", 32'(d_fc[0]),   32'h2);
    ch_valid = '0;
    tick(1);
    pulse_clear();

    // ch0 blocked, clear with stall continuing
    ch_valid[0] = 1'b1;
    tick(16);
    chk("c0_sigs", 32'(d_sigs[0]), 32'h0001);
    pulse_clear();
    chk("c0_clr_sigs", 32'(d_sigs[0]), 32'h0);
    chk("c0_clr_any",  32'(d_any[0]),  32'h0);
    chk("c0_clr_fv",   32'(d_fv[0]),   32'h0);
    tick(15);
    chk("c0_re_pre", 32'(d_sigs[0]), 32'h0);
    tick(1);
    chk("c0_re", 32'(d_sigs[0]), 32'h0001);

    // async reset mid-count
    ch_valid = '0;
    tick(1);
    pulse_clear();
    ch_valid[0] = 1'b1;
    tick(10);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_a", 32'(d_sigs[0]), 32'h0);
    chk("rst_mid_b", 32'(d_sigs[1]), 32'h0);
    chk("rst_mid_any", 32'(d_any[1]), 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(15);
    chk("rst_re_pre", 32'(d_sigs[0]), 32'h0);
    tick(1);
    chk("rst_re", 32'(d_sigs[0]), 32'h0001);
    chk("rst_re_fc", 32'(d_fc[0]), 32'h0);

    // randomized traffic with persistent per-channel handshake levels
    ch_valid = '0;
    ch_ready = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 23) == 0) begin
          ch_valid[i] = 1'($urandom_range(0, 1));
          ch_ready[i] = 1'($urandom_range(0, 1));
        end
      end
      if ($urandom_range(0, 499) == 0) ch_dir[$urandom_range(0, N - 1)] ^= 1'b1;
      enable  = ($urandom_range(0, 299) != 0);
      clear   = ($urandom_range(0, 399) == 0);
      reset_n = 1'b1;
      if ($urandom_range(0, 999) == 0) begin
        #2 reset_n = 1'b0;
      end
      tick(1);
    end
    reset_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aesl_axis_block_detector.md
# aesl_axis_block_detector

Per-channel stall detector that produces the `axis_block_sigs` vector consumed by the cosim deadlock monitors. It watches the valid/ready handshake of each AXI-stream port of the DUT instance and raises that channel's block bit once the channel has been stalled for a programmable number of consecutive cycles. It also latches the first channel to block, for the deadlock report. The block sits in the cosim testbench between the DUT stream ports and the `AESL_deadlock_idx*_monitor` instances.

## Interface
Parameters:
- `NUM_CH`, 13, number of monitored stream channels.
- `STALL_THRESH`, 16, consecutive stalled cycles before a block is declared; legal range 1..2^CNT_W-1.
- `CNT_W`, 16, stall counter width.
- `IDX_W`, `$clog2(NUM_CH)` (minimum 1), width of the channel index.

Ports:
- `clock`, in, 1, single clock; all logic on the rising edge.
- `reset_n`, in, 1, asynchronous, active-low reset.
- `enable`, in, 1, detection enable. While low, all channels are forced to IDLE.
- `clear`, in, 1, synchronous clear of all state and of the latched first-block info.
- `ch_valid`, in, NUM_CH, per-channel TVALID.
- `ch_ready`, in, NUM_CH, per-channel TREADY.
- `ch_dir`, in, NUM_CH, static channel role: 1 = DUT output, 0 = DUT input.
- `axis_block_sigs`, out, NUM_CH, per-channel block flag (registered).
- `any_block`, out, 1, OR of `axis_block_sigs` (registered).
- `first_valid`, out, 1, a first-block channel has been latched.
- `first_ch`, out, IDX_W, index of the first channel to block.

## Operation
- Stall condition `stall[i]`:
  - For `ch_dir[i]=1`: `ch_valid & ~ch_ready`. The DUT is waiting on a full consumer.
  - For `ch_dir[i]=0`: `ch_ready & ~ch_valid`. The DUT is waiting on an empty producer.
- Per-channel FSM with states IDLE, STALL and BLOCKED, and a per-channel counter `cnt[i]`:
  - IDLE: `cnt=0`. If `stall[i]`, go to STALL with `cnt=1`. If additionally `STALL_THRESH==1`, go directly to BLOCKED.
  - STALL: if `~stall[i]`, go to IDLE with `cnt=0`. Else `cnt+1`; when `cnt+1==STALL_THRESH`, go to BLOCKED.
  - BLOCKED: `axis_block_sigs[i]=1`. Leave to IDLE when `~stall[i]`, which includes any transfer (`valid&ready`).
- The counter saturates and never wraps; it is only incremented in STALL.
- First-block latch:
  - When `first_valid=0` and one or more channels enter BLOCKED in the same cycle, latch the lowest such index into `first_ch` and set `first_valid=1`.
  - Both hold until `clear` or reset. Later blocks and un-blocks do not change them.
- Priority per edge: reset_n, then clear, then `enable=0`, then the FSM.
  - `clear` zeroes counters, all FSMs, `first_valid` and `first_ch`.
  - `enable=0` does the same except it preserves `first_valid` and `first_ch`.
- `ch_dir` is treated as static. Changing it mid-run takes effect on the next cycle's stall evaluation, with no other side effect.

## Timing
- Reset values: `axis_block_sigs=0`, `any_block=0`, `first_valid=0`, `first_ch=0`, all FSMs IDLE, all counters 0.
- If `stall[i]` is high in cycles 0..STALL_THRESH-1, `axis_block_sigs[i]` is high from cycle STALL_THRESH onward.
- Block deassertion: `stall[i]` low in cycle k means `axis_block_sigs[i]` is low in cycle k+1.
- `any_block` is computed from next-state values and registered, so it rises in the same cycle as the block bit.
- `first_valid` and `first_ch` update in the same cycle as the first block bit.
- A single non-stalled cycle restarts the count; there is no hysteresis.
- Reset asserted mid-stall clears everything asynchronously. Counting restarts from IDLE after release.

## Structure
- Shared package `aesl_deadlock_pkg`:
  - `ch_state_t` enum: IDLE=2'd0, STALL=2'd1, BLOCKED=2'd2.
  - Direction constants `DIR_IN=1'b0` and `DIR_OUT=1'b1`.
- Sub-module `aesl_axis_stall_ch`: one channel's FSM and counter. It is instantiated NUM_CH times with a generate loop.
- The top level holds the first-block priority encoder, the latch and the `any_block` OR.

## Test plan
- STALL_THRESH=16, ch 3 output role with valid=1, ready=0 for 16 cycles. Expect `axis_block_sigs=13'h0008` at cycle 16, `any_block=1`, `first_ch=3`, `first_valid=1`.
- Ch 5 input role with ready=1, valid=0 for 15 cycles, then valid=1 for one cycle, then 15 more stalled cycles. Expect the block bit never asserts.
- Chs 2 and 9 start stalling on the same cycle. Expect both block bits to rise together and `first_ch=2`. Release ch 2: bit 2 drops the next cycle and `first_ch` stays 2.
- Ch 0 blocked, then `clear` pulsed for 1 cycle with the stall continuing. Expect all outputs 0 the next cycle, then bit 0 re-asserts 16 cycles later.
- `reset_n` pulsed low mid-count, after 10 stalled cycles. Expect outputs 0 immediately; the block occurs 16 cycles after release.
- STALL_THRESH=1. Expect the block asserts one cycle after the first stalled cycle.
